// File: rtl/id_ex_stage_if.sv
// Bundle of the decode-side, forwarding and EX-side signals of the ID/EX stage.
// The master drives decode and forwarding inputs; the slave (the stage) drives the EX outputs.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        exmem_wr;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_res;
    logic        memwb_wr;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  opselect;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  shamt;
    logic [4:0]  ex_rd;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [31:0] ex_store_data;
    logic        illegal;

    modport master (
        output id_valid, instr, rs_data, rt_data, flush,
        output exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_data,
        input  stall, ex_valid, opselect, x, y, shamt, ex_rd,
        input  ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data, illegal
    );

    modport slave (
        input  id_valid, instr, rs_data, rt_data, flush,
        input  exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_data,
        output stall, ex_valid, opselect, x, y, shamt, ex_rd,
        output ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data, illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX stage: MIPS decode into ALU opselect/operands, one register stage, hazard stall and bubbles.
// Define ID_EX_FWD_EN for EX/MEM and MEM/WB operand forwarding (hazard reduces to load-use only).
module id_ex_stage (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_idx_s, rt_idx_s, rd_idx_s;
    logic [31:0] sext_s, zext_s;
    logic        legal_s, hazard_s, issue_s, load_s;
    logic [4:0]  dec_op_s, dec_shamt_s, dec_rd_s, dec_xsrc_s, dec_ysrc_s, dec_ssrc_s;
    logic [31:0] dec_x_s, dec_y_s;
    logic        dec_reg_wr_s, dec_mem_rd_s, dec_mem_wr_s;

    logic        ex_valid_d, ex_valid_q, ex_reg_wr_d, ex_reg_wr_q;
    logic        ex_mem_rd_d, ex_mem_rd_q, ex_mem_wr_d, ex_mem_wr_q, illegal_d, illegal_q;
    logic [4:0]  opselect_d, opselect_q, shamt_d, shamt_q, ex_rd_d, ex_rd_q;
    logic [31:0] x_d, x_q, y_d, y_q, store_d, store_q;

    // Source index 0 means "operand not read from the register file".
    function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c);
        return (dst != 5'd0) && ((dst == a) || (dst == b) || (dst == c));
    endfunction

    assign opcode_s = bus.instr[31:26];
    assign funct_s  = bus.instr[5:0];
    assign rs_idx_s = bus.instr[25:21];
    assign rt_idx_s = bus.instr[20:16];
    assign rd_idx_s = bus.instr[15:11];
    assign sext_s   = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign zext_s   = {16'h0000, bus.instr[15:0]};

    // Instruction decode into ALU controls, operand values and operand source indices
    always_comb begin
        legal_s      = 1'b1;
        dec_op_s     = 5'd0;
        dec_shamt_s  = 5'd0;
        dec_rd_s     = rd_idx_s;
        dec_x_s      = bus.rs_data;
        dec_xsrc_s   = rs_idx_s;
        dec_y_s      = bus.rt_data;
        dec_ysrc_s   = rt_idx_s;
        dec_ssrc_s   = 5'd0;
        dec_reg_wr_s = 1'b1;
        dec_mem_rd_s = 1'b0;
        dec_mem_wr_s = 1'b0;
        case (opcode_s)
            6'h00: begin
                case (funct_s)
                    6'h20, 6'h21: dec_op_s = 5'b00000;
                    6'h22, 6'h23: dec_op_s = 5'b00001;
                    6'h24: dec_op_s = 5'b01001;
                    6'h25: dec_op_s = 5'b01010;
                    6'h26: dec_op_s = 5'b01101;
                    6'h27: dec_op_s = 5'b01100;
                    6'h2A: dec_op_s = 5'b00111;
                    6'h2B: dec_op_s = 5'b00010;
                    6'h00, 6'h02, 6'h03: begin
                        dec_op_s    = (funct_s == 6'h00) ? 5'b00101 :
                                      (funct_s == 6'h02) ? 5'b01111 : 5'b01011;
                        dec_x_s     = bus.rt_data;
                        dec_xsrc_s  = rt_idx_s;
                        dec_y_s     = 32'h0;
                        dec_ysrc_s  = 5'd0;
                        dec_shamt_s = bus.instr[10:6];
                    end
                    6'h04, 6'h06, 6'h07: begin
                        dec_op_s   = (funct_s == 6'h04) ? 5'b00100 :
                                     (funct_s == 6'h06) ? 5'b01110 : 5'b00011;
                        dec_x_s    = bus.rt_data;
                        dec_xsrc_s = rt_idx_s;
                        dec_y_s    = bus.rs_data;
                        dec_ysrc_s = rs_idx_s;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                dec_op_s   = (opcode_s == 6'h0A) ? 5'b00111 :
                             (opcode_s == 6'h0B) ? 5'b00010 : 5'b00000;
                dec_rd_s   = rt_idx_s;
                dec_y_s    = sext_s;
                dec_ysrc_s = 5'd0;
                dec_mem_rd_s = (opcode_s == 6'h23);
                dec_mem_wr_s = (opcode_s == 6'h2B);
                dec_reg_wr_s = (opcode_s != 6'h2B);
                dec_ssrc_s   = (opcode_s == 6'h2B) ? rt_idx_s : 5'd0;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_op_s   = (opcode_s == 6'h0C) ? 5'b01001 :
                             (opcode_s == 6'h0D) ? 5'b01010 : 5'b01101;
                dec_rd_s   = rt_idx_s;
                dec_y_s    = zext_s;
                dec_ysrc_s = 5'd0;
            end
            6'h0F: begin
                dec_op_s    = 5'b00101;
                dec_rd_s    = rt_idx_s;
                dec_x_s     = zext_s;
                dec_xsrc_s  = 5'd0;
                dec_y_s     = 32'h0;
                dec_ysrc_s  = 5'd0;
                dec_shamt_s = 5'd16;
            end
            6'h04, 6'h05: begin
                dec_op_s     = (opcode_s == 6'h04) ? 5'b01000 : 5'b10010;
                dec_rd_s     = rt_idx_s;
                dec_reg_wr_s = 1'b0;
            end
            default: legal_s = 1'b0;
        endcase
        dec_reg_wr_s = dec_reg_wr_s & (dec_rd_s != 5'd0);
    end

`ifdef ID_EX_FWD_EN
    logic [4:0] xsrc_d, xsrc_q, ysrc_d, ysrc_q, ssrc_d, ssrc_q;

    // EX/MEM result beats MEM/WB data beats the value captured at decode.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regv,
                                        input logic em_wr, input logic [4:0] em_rd,
                                        input logic [31:0] em_res, input logic mw_wr,
                                        input logic [4:0] mw_rd, input logic [31:0] mw_data);
        if (em_wr && em_rd != 5'd0 && em_rd == src) return em_res;
        else if (mw_wr && mw_rd != 5'd0 && mw_rd == src) return mw_data;
        else return regv;
    endfunction

    assign hazard_s = legal_s & ex_valid_q & ex_mem_rd_q &
                      src_hit(ex_rd_q, dec_xsrc_s, dec_ysrc_s, dec_ssrc_s);

    // Source tags follow the instruction into EX; bubbles carry no sources
    always_comb begin
        xsrc_d = load_s ? dec_xsrc_s : 5'd0;
        ysrc_d = load_s ? dec_ysrc_s : 5'd0;
        ssrc_d = load_s ? dec_ssrc_s : 5'd0;
    end

    // Source-tag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            xsrc_q <= 5'd0;
            ysrc_q <= 5'd0;
            ssrc_q <= 5'd0;
        end else begin
            xsrc_q <= xsrc_d;
            ysrc_q <= ysrc_d;
            ssrc_q <= ssrc_d;
        end
    end

    assign bus.x = fwd(xsrc_q, x_q, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                       bus.memwb_wr, bus.memwb_rd, bus.memwb_data);
    assign bus.y = fwd(ysrc_q, y_q, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                       bus.memwb_wr, bus.memwb_rd, bus.memwb_data);
    assign bus.ex_store_data = fwd(ssrc_q, store_q, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                                   bus.memwb_wr, bus.memwb_rd, bus.memwb_data);
`else
    // Without forwarding, wait until any in-flight producer has reached the write-before-read regfile.
    assign hazard_s = legal_s &
        ((ex_valid_q & ex_reg_wr_q & src_hit(ex_rd_q, dec_xsrc_s, dec_ysrc_s, dec_ssrc_s)) |
         (bus.exmem_wr & src_hit(bus.exmem_rd, dec_xsrc_s, dec_ysrc_s, dec_ssrc_s)));
    assign bus.x             = x_q;
    assign bus.y             = y_q;
    assign bus.ex_store_data = store_q;
`endif

    assign issue_s   = bus.id_valid & ~bus.flush & ~hazard_s;
    assign load_s    = issue_s & legal_s;
    assign bus.stall = ~rst & bus.id_valid & ~bus.flush & hazard_s;

    // Next EX contents: a bubble unless a legal instruction issues this cycle
    always_comb begin
        ex_valid_d  = 1'b0;
        opselect_d  = 5'd0;
        x_d         = 32'h0;
        y_d         = 32'h0;
        shamt_d     = 5'd0;
        ex_rd_d     = 5'd0;
        ex_reg_wr_d = 1'b0;
        ex_mem_rd_d = 1'b0;
        ex_mem_wr_d = 1'b0;
        store_d     = 32'h0;
        illegal_d   = issue_s & ~legal_s;
        if (load_s) begin
            ex_valid_d  = 1'b1;
            opselect_d  = dec_op_s;
            x_d         = dec_x_s;
            y_d         = dec_y_s;
            shamt_d     = dec_shamt_s;
            ex_rd_d     = dec_rd_s;
            ex_reg_wr_d = dec_reg_wr_s;
            ex_mem_rd_d = dec_mem_rd_s;
            ex_mem_wr_d = dec_mem_wr_s;
            store_d     = bus.rt_data;
        end else begin
            ex_valid_d  = 1'b0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            opselect_q  <= 5'd0;
            x_q         <= 32'h0;
            y_q         <= 32'h0;
            shamt_q     <= 5'd0;
            ex_rd_q     <= 5'd0;
            ex_reg_wr_q <= 1'b0;
            ex_mem_rd_q <= 1'b0;
            ex_mem_wr_q <= 1'b0;
            store_q     <= 32'h0;
            illegal_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            opselect_q  <= opselect_d;
            x_q         <= x_d;
            y_q         <= y_d;
            shamt_q     <= shamt_d;
            ex_rd_q     <= ex_rd_d;
            ex_reg_wr_q <= ex_reg_wr_d;
            ex_mem_rd_q <= ex_mem_rd_d;
            ex_mem_wr_q <= ex_mem_wr_d;
            store_q     <= store_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.opselect  = opselect_q;
    assign bus.shamt     = shamt_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_reg_wr = ex_reg_wr_q;
    assign bus.ex_mem_rd = ex_mem_rd_q;
    assign bus.ex_mem_wr = ex_mem_wr_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding vectors run only when ID_EX_FWD_EN is defined.
module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic fl);
        bus.id_valid = v;
        bus.instr    = ins;
        bus.rs_data  = rsd;
        bus.rt_data  = rtd;
        bus.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        bus.exmem_wr = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_res = 32'h0;
        bus.memwb_wr = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_data = 32'h0;
        rst = 1'b1;
        drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 1'b0);
        #1;
        check_val("rst_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        check_val("rst_valid", {31'h0, bus.ex_valid}, 32'h0);
        check_val("rst_op", {27'h0, bus.opselect}, 32'h0);
        check_val("rst_x", bus.x, 32'h0);
        check_val("rst_y", bus.y, 32'h0);
        check_val("rst_regwr", {31'h0, bus.ex_reg_wr}, 32'h0);
        check_val("rst_illegal", {31'h0, bus.illegal}, 32'h0);

        rst = 1'b0;
        tick();
        check_val("add_op", {27'h0, bus.opselect}, 32'h0);
        check_val("add_x", bus.x, 32'd5);
        check_val("add_y", bus.y, 32'd7);
        check_val("add_rd", {27'h0, bus.ex_rd}, 32'd3);
        check_val("add_regwr", {31'h0, bus.ex_reg_wr}, 32'h1);
        check_val("add_valid", {31'h0, bus.ex_valid}, 32'h1);

        drive(1'b1, rtype(5'd0, 5'd5, 5'd4, 5'd3, 6'h03), 32'h0, 32'h8000_0000, 1'b0);
        tick();
        check_val("sra_op", {27'h0, bus.opselect}, 32'h0000_000B);
        check_val("sra_x", bus.x, 32'h8000_0000);
        check_val("sra_shamt", {27'h0, bus.shamt}, 32'd3);
        check_val("sra_rd", {27'h0, bus.ex_rd}, 32'd4);

        drive(1'b1, itype(6'h0F, 5'd0, 5'd1, 16'h1234), 32'h0, 32'h0, 1'b0);
        tick();
        check_val("lui_op", {27'h0, bus.opselect}, 32'h5);
        check_val("lui_x", bus.x, 32'h0000_1234);
        check_val("lui_shamt", {27'h0, bus.shamt}, 32'd16);
        check_val("lui_rd", {27'h0, bus.ex_rd}, 32'd1);

        drive(1'b1, rtype(5'd7, 5'd8, 5'd6, 5'd0, 6'h22), 32'd10, 32'd3, 1'b0);
        tick();
        check_val("sub_op", {27'h0, bus.opselect}, 32'h1);
        check_val("sub_x", bus.x, 32'd10);

        drive(1'b1, itype(6'h0C, 5'd10, 5'd9, 16'hFFFF), 32'h0F0F_0F0F, 32'h0, 1'b0);
        tick();
        check_val("andi_op", {27'h0, bus.opselect}, 32'h9);
        check_val("andi_y", bus.y, 32'h0000_FFFF);

        drive(1'b1, itype(6'h08, 5'd10, 5'd9, 16'hFFFF), 32'h0F0F_0F0F, 32'h0, 1'b0);
        tick();
        check_val("addi_op", {27'h0, bus.opselect}, 32'h0);
        check_val("addi_y", bus.y, 32'hFFFF_FFFF);
        check_val("addi_rd", {27'h0, bus.ex_rd}, 32'd9);

        drive(1'b1, rtype(5'd13, 5'd12, 5'd11, 5'd0, 6'h04), 32'd4, 32'd1, 1'b0);
        tick();
        check_val("sllv_op", {27'h0, bus.opselect}, 32'h4);
        check_val("sllv_x", bus.x, 32'd1);
        check_val("sllv_y", bus.y, 32'd4);

        drive(1'b1, rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd1, 32'd2, 1'b0);
        tick();
        check_val("rd0_valid", {31'h0, bus.ex_valid}, 32'h1);
        check_val("rd0_regwr", {31'h0, bus.ex_reg_wr}, 32'h0);

        drive(1'b1, rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'd1, 32'd2, 1'b0);
        #1;
        check_val("mult_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        check_val("mult_illegal", {31'h0, bus.illegal}, 32'h1);
        check_val("mult_valid", {31'h0, bus.ex_valid}, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check_val("illegal_clear", {31'h0, bus.illegal}, 32'h0);

        drive(1'b1, itype(6'h04, 5'd1, 5'd1, 16'h0010), 32'd7, 32'd7, 1'b0);
        tick();
        check_val("beq_op", {27'h0, bus.opselect}, 32'h8);
        check_val("beq_x", bus.x, 32'd7);
        check_val("beq_y", bus.y, 32'd7);
        check_val("beq_regwr", {31'h0, bus.ex_reg_wr}, 32'h0);

        drive(1'b1, itype(6'h2B, 5'd6, 5'd5, 16'h0004), 32'd100, 32'h0000_DEAD, 1'b0);
        tick();
        check_val("sw_x", bus.x, 32'd100);
        check_val("sw_y", bus.y, 32'd4);
        check_val("sw_memwr", {31'h0, bus.ex_mem_wr}, 32'h1);
        check_val("sw_regwr", {31'h0, bus.ex_reg_wr}, 32'h0);
        check_val("sw_data", bus.ex_store_data, 32'h0000_DEAD);

        drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'd8, 32'h0, 1'b0);
        tick();
        check_val("lw_memrd", {31'h0, bus.ex_mem_rd}, 32'h1);
        check_val("lw_rd", {27'h0, bus.ex_rd}, 32'd2);
        drive(1'b1, rtype(5'd2, 5'd2, 5'd3, 5'd0, 6'h20), 32'd20, 32'd20, 1'b0);
        #1;
        check_val("lu_stall", {31'h0, bus.stall}, 32'h1);
        tick();
        check_val("lu_bubble", {31'h0, bus.ex_valid}, 32'h0);
        check_val("lu_bubble_wr", {31'h0, bus.ex_reg_wr}, 32'h0);
        check_val("lu_stall_end", {31'h0, bus.stall}, 32'h0);
        tick();
        check_val("lu_issue_valid", {31'h0, bus.ex_valid}, 32'h1);
        check_val("lu_issue_rd", {27'h0, bus.ex_rd}, 32'd3);
        check_val("lu_issue_x", bus.x, 32'd20);

        drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'd8, 32'h0, 1'b0);
        tick();
        drive(1'b1, rtype(5'd2, 5'd2, 5'd3, 5'd0, 6'h20), 32'd20, 32'd20, 1'b1);
        #1;
        check_val("flush_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        check_val("flush_bubble", {31'h0, bus.ex_valid}, 32'h0);
        check_val("flush_op", {27'h0, bus.opselect}, 32'h0);

`ifdef ID_EX_FWD_EN
        drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.exmem_wr = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_res = 32'd99;
        #1;
        check_val("fwd_em_x", bus.x, 32'd99);
        check_val("fwd_em_y", bus.y, 32'd7);
        bus.memwb_wr = 1'b1; bus.memwb_rd = 5'd1; bus.memwb_data = 32'd55;
        #1;
        check_val("fwd_both_x", bus.x, 32'd99);
        bus.exmem_wr = 1'b0;
        #1;
        check_val("fwd_mw_x", bus.x, 32'd55);
        bus.memwb_rd = 5'd0;
        #1;
        check_val("fwd_r0_x", bus.x, 32'd5);
        bus.memwb_wr = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
